trdb_branch_map: RTL
====================

Name: trdb_branch_map

Overview:
Collects the taken/not-taken outcome of each retired conditional branch from the core's instruction trace into a compact branch map. The map is handed to the packet emitter once it is full or a flush is requested. It sits directly downstream of the retired-instruction interface (ivalid/iaddr/instr/compressed) after branch decode, and upstream of the trace packet encoder. It is double-buffered so that accumulation can continue while a completed map waits for the encoder.

Parameters:
MAP_LEN, 31, maximum number of branch outcomes held per map (1..31)
CNT_W, 5, width of branch count; must satisfy 2**CNT_W > MAP_LEN

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
branch_valid_i  in  1  one retired conditional branch this cycle
branch_taken_i  in  1  outcome of that branch (1 = taken)
flush_i  in  1  request emission of the current partial map
clear_i  in  1  synchronous clear of overflow_o
map_o  out  MAP_LEN  emitted map; bit k = outcome of k-th branch, 1 = NOT taken
branches_o  out  CNT_W  number of valid bits in map_o (1..MAP_LEN)
map_valid_o  out  1  emitted map valid
map_ready_i  in  1  encoder accepts map (transfer when valid && ready)
full_o  out  1  accumulator holds MAP_LEN branches
empty_o  out  1  accumulator holds 0 branches
overflow_o  out  1  sticky: a branch was dropped

Behaviour:
- Reset (async, rst_ni=0): accumulator bits=0, count=0, map_o=0, branches_o=0, map_valid_o=0, overflow_o=0, flush_pending=0. empty_o=1, full_o=0.
- Accumulator: on branch_valid_i, bit[count] <= ~branch_taken_i and count <= count+1. Bits at or above count are don't-care, but they are driven as 0 at the output.
- Output slot free = !map_valid_o || map_ready_i. A slot being freed this cycle by a transfer counts as free.
- Handoff trigger (evaluated on the effective accumulator, i.e. including the branch arriving this cycle):
  - eff_count == MAP_LEN, or
  - (flush_i || flush_pending) && eff_count > 0.
- Handoff with slot free: map_o <= effective bits, branches_o <= eff_count, map_valid_o <= 1, accumulator count <= 0, flush_pending <= 0.
  - Latency: map_valid_o rises the cycle after the completing branch or flush.
- Handoff with slot not free:
  - Accumulator keeps its content.
  - flush_i sets flush_pending.
  - Handoff retries every cycle until the slot frees.
- Flush with eff_count == 0: no packet, flush_pending cleared.
- Accumulator full, slot occupied, and branch_valid_i=1: the branch is dropped and overflow_o <= 1. No other state changes.
- Accumulator full, slot freed this same cycle, and branch_valid_i=1: the full map transfers, and the new branch becomes bit 0 of the fresh accumulator (count=1).
- map_valid_o holds, with map_o and branches_o stable, until a transfer.
  - After a transfer with no new handoff: map_valid_o <= 0.
  - Back-to-back transfers are allowed: one map per cycle maximum.
- overflow_o clears only on clear_i. If clear_i and a drop happen in the same cycle, the set wins.
- full_o / empty_o reflect the registered count (count==MAP_LEN / count==0).
- Encoding: two-state output FSM, IDLE (map_valid_o=0) ⇄ PEND (map_valid_o=1). The accumulator is a counter plus shift-free indexed write.

Test Plan:
- 31 branches, alternating taken/not-taken starting with taken, map_ready_i=1 → one cycle after the 31st: map_valid_o=1, branches_o=31, map_o=31'h2AAAAAAA; next cycle empty_o=1.
- 3 branches (T,N,T) then flush_i → map_o=3'b010 in the low bits (rest 0), branches_o=3, map_valid_o for exactly 1 cycle with ready=1.
- flush_i on the same cycle as a 5th branch (not taken) with 4 taken before it → branches_o=5, map_o=5'b10000.
- map_ready_i=0, fill 31 then 31 more branches, then 1 extra → first map held stable, full_o=1, extra branch dropped, overflow_o=1. Raise ready: two maps transfer on consecutive cycles. clear_i → overflow_o=0.
- flush_i while PEND and accumulator has 2 branches → no second map until ready. After the transfer, the next cycle presents branches_o=2.
- flush_i with empty accumulator, then rst_ni asserted mid-PEND → no packet; all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/trdb_branch_map.sv
// trdb_branch_map
// Packs the taken/not-taken outcomes of retired conditional branches into a
// branch map (bit k = k-th branch, 1 = NOT taken). When the map is full or a
// flush is requested, it is handed to the packet encoder. There are two
// stages: the accumulator and one output slot. A completed map can therefore
// wait for the encoder while new branches keep accumulating.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   branch_valid_i     one retired conditional branch this cycle
//   branch_taken_i     its outcome (1 = taken)
//   flush_i            emit the current partial map
//   clear_i            synchronous clear of overflow_o
//   map_o/branches_o   emitted map and its number of valid bits
//   map_valid_o        emitted map valid (transfer on valid && map_ready_i)
//   map_ready_i        encoder accepts the map
//   full_o/empty_o     accumulator holds MAP_LEN / 0 branches
//   overflow_o         sticky: a branch was dropped
//
// Output FSM:
//   state | meaning
//   IDLE  | output slot empty, map_valid_o = 0
//   PEND  | map held in output slot, map_valid_o = 1

module trdb_branch_map #(
    parameter int unsigned MAP_LEN = 31,
    parameter int unsigned CNT_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               branch_valid_i,
    input  logic               branch_taken_i,
    input  logic               flush_i,
    input  logic               clear_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   branches_o,
    output logic               map_valid_o,
    input  logic               map_ready_i,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_o
);

    typedef enum logic {IDLE, PEND} state_e;

    localparam logic [CNT_W-1:0] MAP_LEN_C = CNT_W'(MAP_LEN);

    state_e             state_q;
    logic [MAP_LEN-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               flush_pend_q;
    logic               overflow_q;
    logic [MAP_LEN-1:0] map_q;
    logic [CNT_W-1:0]   br_q;

    logic               acc_full;
    logic               slot_free;
    logic               branch_in;
    logic               any_flush;
    logic               trigger;
    logic               handoff;
    logic               drop;
    logic [CNT_W-1:0]   eff_cnt;
    logic [MAP_LEN-1:0] eff_bits;
    logic [MAP_LEN-1:0] out_bits;

    assign acc_full  = (cnt_q == MAP_LEN_C);
    // A slot that is being emptied by a transfer this cycle counts as free.
    assign slot_free = (state_q == IDLE) || map_ready_i;
    // A full accumulator cannot take the branch. The branch either starts
    // the next map (when the full map leaves this cycle) or is dropped.
    assign branch_in = branch_valid_i && !acc_full;
    assign any_flush = flush_i || flush_pend_q;
    assign eff_cnt   = cnt_q + CNT_W'(branch_in);
    assign trigger   = (eff_cnt == MAP_LEN_C) || (any_flush && (eff_cnt != '0));
    assign handoff   = trigger && slot_free;
    assign drop      = branch_valid_i && acc_full && !slot_free;

    // Effective accumulator, including this cycle's branch. Bits at or above
    // eff_cnt are zeroed so that stale bits are never emitted.
    always_comb begin
        eff_bits = acc_q;
        out_bits = '0;
        for (int k = 0; k < int'(MAP_LEN); k++) begin
            if (branch_in && (cnt_q == CNT_W'(k))) begin
                eff_bits[k] = ~branch_taken_i;
            end
            out_bits[k] = eff_bits[k] && (CNT_W'(k) < eff_cnt);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            map_q        <= '0;
            br_q         <= '0;
        end else begin
            if (handoff) begin
                state_q      <= PEND;
                map_q        <= out_bits;
                br_q         <= eff_cnt;
                flush_pend_q <= 1'b0;
                if (branch_valid_i && acc_full) begin
                    acc_q[0] <= ~branch_taken_i;
                    cnt_q    <= CNT_W'(1);
                end else begin
                    cnt_q    <= '0;
                end
            end else begin
                if (state_q == PEND && map_ready_i) begin
                    state_q <= IDLE;
                end
                if (branch_in) begin
                    acc_q <= eff_bits;
                    cnt_q <= eff_cnt;
                end
                // A flush with nothing to send is dropped. Otherwise it is
                // held until the slot frees.
                if (any_flush) begin
                    flush_pend_q <= (eff_cnt != '0);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign map_o       = map_q;
    assign branches_o  = br_q;
    assign map_valid_o = (state_q == PEND);
    assign full_o      = acc_full;
    assign empty_o     = (cnt_q == '0);
    assign overflow_o  = overflow_q;

endmodule
